// File: rtl/fifo_pkg.sv
// Shared types and the FIFO's read-acceptance rule for the stream reader
// and anything else that models the same FIFO.
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;

    // A write that the FIFO accepts takes priority and suppresses any read that cycle.
    function automatic logic read_accepted(input logic rd_en, input logic empty,
                                           input logic wr_en, input logic full);
        return rd_en && !empty && !(wr_en && !full);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-side and output-stream signals of the stream reader.
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 4);

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_full, fifo_wr_en, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_full, fifo_wr_en, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer; push and pop in the same cycle are both honoured.
module stream_skid_buf #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  head;
    logic                  tail;

    assign valid = (occ != 2'd0);
    assign pop   = valid && ready;
    assign data  = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a 1-cycle-latency FIFO and re-presents its words as a framed
// valid/ready stream with m_last every BURST_LEN beats.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    rd_state_e     state, state_nxt;
    logic          inflight;
    logic          pop;
    logic          last_hold;
    logic          drain_close;
    logic [1:0]    occ;
    logic [2:0]    budget;
    logic [CW-1:0] beat_cnt;

    stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .ready     (bus.m_ready),
        .valid     (bus.m_valid),
        .pop       (pop),
        .data      (bus.m_data),
        .occ       (occ)
    );

    // Words owed to the buffer after this cycle's pop; one more read only fits if <= 1.
    assign budget = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign bus.fifo_rd_en = !rst && (state == RUN) && enable && !bus.fifo_empty
                            && (budget <= 3'd1);

    assign drain_close = (state == DRAIN) && (occ == 2'd1) && !inflight;
    // last_hold keeps m_last stable if a drain-closing beat stalls and RUN resumes.
    assign bus.m_last  = bus.m_valid &&
                         ((beat_cnt == CW'(BURST_LEN - 1)) || drain_close || last_hold);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable)                         state_nxt = RUN;
                else if (occ == 2'd0 && !inflight)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            inflight  <= 1'b0;
            last_hold <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            inflight  <= read_accepted(bus.fifo_rd_en, bus.fifo_empty,
                                       bus.fifo_wr_en, bus.fifo_full);
            last_hold <= bus.m_last && !bus.m_ready;
            if (pop) beat_cnt <= bus.m_last ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO plus a stream monitor; expected
// output is the FIFO write order framed every BL beats.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int DW = 4, BL = 4, DEPTH = 16;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, busy;
    int   errors = 0, checks = 0;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural FIFO: write wins over read, registered data_out.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wdata = '0, fdata;
    logic [DW-1:0] wr_log [$];
    int wp, rp, cnt;

    assign bus.fifo_empty = (cnt == 0);
    assign bus.fifo_full  = (cnt == DEPTH);
    assign bus.fifo_data  = fdata;

    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0; wp <= 0; rp <= 0; fdata <= '0;
        end else if (bus.fifo_wr_en && cnt < DEPTH) begin
            mem[wp] <= wdata; wp <= (wp + 1) % DEPTH; cnt <= cnt + 1;
            wr_log.push_back(wdata);
        end else if (bus.fifo_rd_en && cnt > 0) begin
            fdata <= mem[rp]; rp <= (rp + 1) % DEPTH; cnt <= cnt - 1;
        end
    end

    // Monitor: logs transfers, stall stability and words owed to the stream.
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int            got_c [$];
    int            cyc_n = 0, outstanding = 0, stall_viol = 0, ovf_viol = 0;
    logic          prev_stall = 1'b0, prev_l = 1'b0, pop_now, acc_now;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            pop_now = bus.m_valid && bus.m_ready;
            acc_now = read_accepted(bus.fifo_rd_en, cnt == 0, bus.fifo_wr_en, cnt == DEPTH);
            if (prev_stall && !(bus.m_valid && bus.m_data == prev_d && bus.m_last == prev_l))
                stall_viol++;
            if (bus.fifo_rd_en && (outstanding - int'(pop_now)) >= 2) ovf_viol++;
            if (pop_now) begin
                got_d.push_back(bus.m_data); got_l.push_back(bus.m_last); got_c.push_back(cyc_n);
            end
            outstanding = outstanding + int'(acc_now) - int'(pop_now);
            prev_stall  = bus.m_valid && !bus.m_ready;
            prev_d      = bus.m_data;
            prev_l      = bus.m_last;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; bus.fifo_wr_en = 1'b0; bus.m_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic preload(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            bus.fifo_wr_en = 1'b1;
            wdata = seq ? DW'(i + 1) : DW'($urandom);
            cyc();
        end
        bus.fifo_wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && busy; k++) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; bus.fifo_wr_en = 1'b0; bus.m_ready = 1'b1;
        repeat (2) cyc();
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); end
        enable = 1'b0; rst = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", bus.m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stream();
        int wb, gb, t_rd, t_v;
        do_reset(); wb = wr_log.size(); gb = got_d.size();
        preload(8, 1'b1);
        bus.m_ready = 1'b1; enable = 1'b1;
        t_rd = -1; t_v = -1;
        for (int k = 0; k < 20 && t_v < 0; k++) begin
            cyc();
            if (bus.fifo_rd_en && t_rd < 0) t_rd = k;
            if (bus.m_valid) t_v = k;
        end
        checks++; if (t_rd < 0 || t_v - t_rd !== 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", t_v - t_rd); end
        repeat (12) cyc();
        enable = 1'b0; wait_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b exp=0", busy); end
        checks++; if (got_d.size() - gb !== 8) begin errors++; $display("FAIL stream_count got=%0d exp=8", got_d.size() - gb); end
        for (int i = 0; i < 8 && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== DW'(i + 1) || got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got_d[gb+i], DW'(i + 1)); end
            checks++; if (got_l[gb+i] !== (i % BL == BL - 1)) begin errors++; $display("FAIL stream_last[%0d] got=%b exp=%b", i, got_l[gb+i], i % BL == BL - 1); end
            checks++; if (got_c[gb+i] !== got_c[gb] + i) begin errors++; $display("FAIL stream_gap[%0d] got=%0d exp=%0d", i, got_c[gb+i], got_c[gb] + i); end
        end
    endtask

    task automatic test_backpressure();
        int wb, gb, sv0, ov0;
        do_reset(); wb = wr_log.size(); gb = got_d.size(); sv0 = stall_viol; ov0 = ovf_viol;
        preload(8, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin bus.m_ready = (k % 2 == 0); cyc(); end
        bus.m_ready = 1'b1; repeat (4) cyc();
        enable = 1'b0; wait_idle();
        checks++; if (got_d.size() - gb !== 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got_d.size() - gb); end
        for (int i = 0; i < 8 && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_d[gb+i], wr_log[wb+i]); end
            checks++; if (got_l[gb+i] !== (i % BL == BL - 1)) begin errors++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_l[gb+i], i % BL == BL - 1); end
        end
        checks++; if (stall_viol - sv0 !== 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol - sv0); end
        checks++; if (ovf_viol - ov0 !== 0) begin errors++; $display("FAIL bp_overissue got=%0d exp=0", ovf_viol - ov0); end
    endtask

    task automatic test_write_collision();
        int wb, gb;
        do_reset(); wb = wr_log.size(); gb = got_d.size();
        preload(3, 1'b0);
        bus.m_ready = 1'b1; enable = 1'b1;
        cyc();
        checks++; if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL coll_first_rd got=%b exp=1", bus.fifo_rd_en); end
        bus.fifo_wr_en = 1'b1; wdata = DW'($urandom);
        cyc();
        bus.fifo_wr_en = 1'b0;
        cyc();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL coll_no_capture got=%b exp=0", bus.m_valid); end
        repeat (10) cyc();
        enable = 1'b0; wait_idle();
        checks++; if (got_d.size() - gb !== 4) begin errors++; $display("FAIL coll_count got=%0d exp=4", got_d.size() - gb); end
        for (int i = 0; i < 4 && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL coll_data[%0d] got=%h exp=%h", i, got_d[gb+i], wr_log[wb+i]); end
            checks++; if (got_l[gb+i] !== (i == 3)) begin errors++; $display("FAIL coll_last[%0d] got=%b exp=%b", i, got_l[gb+i], i == 3); end
        end
    endtask

    task automatic test_drain();
        int wb, gb, total;
        do_reset(); wb = wr_log.size(); gb = got_d.size();
        preload(6, 1'b0);
        bus.m_ready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 20 && !(bus.m_valid && got_d.size() - gb == 1); k++) cyc();
        // beat 2 pops this cycle; everything owed to the stream is still delivered
        total = 1 + outstanding;
        checks++; if (outstanding !== 2) begin errors++; $display("FAIL drain_inflight got=%0d exp=2", outstanding); end
        enable = 1'b0;
        cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got=%b exp=1", busy); end
        wait_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b exp=0", busy); end
        checks++; if (got_d.size() - gb !== total) begin errors++; $display("FAIL drain_count got=%0d exp=%0d", got_d.size() - gb, total); end
        for (int i = 0; i < total && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, got_d[gb+i], wr_log[wb+i]); end
            checks++; if (got_l[gb+i] !== (i == total - 1 || i % BL == BL - 1)) begin errors++; $display("FAIL drain_last[%0d] got=%b exp=%b", i, got_l[gb+i], i == total - 1 || i % BL == BL - 1); end
        end
        checks++; if (cnt !== 6 - total) begin errors++; $display("FAIL drain_fifo_left got=%0d exp=%0d", cnt, 6 - total); end
    endtask

    task automatic test_reset_mid();
        int wb, gb;
        do_reset();
        preload(5, 1'b0);
        bus.m_ready = 1'b0; enable = 1'b1;
        for (int k = 0; k < 10 && outstanding != 2; k++) cyc();
        rst = 1'b1;
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_rd_in_rst got=%b exp=0", bus.fifo_rd_en); end
        cyc();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL rmid_last got=%b exp=0", bus.m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        rst = 1'b0; enable = 1'b0;
        cyc();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_discard got=%b exp=0", bus.m_valid); end
        wb = wr_log.size(); gb = got_d.size();
        preload(4, 1'b0);
        bus.m_ready = 1'b1; enable = 1'b1;
        repeat (12) cyc();
        enable = 1'b0; wait_idle();
        checks++; if (got_d.size() - gb !== 4) begin errors++; $display("FAIL rmid_count got=%0d exp=4", got_d.size() - gb); end
        for (int i = 0; i < 4 && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL rmid_data[%0d] got=%h exp=%h", i, got_d[gb+i], wr_log[wb+i]); end
            checks++; if (got_l[gb+i] !== (i == 3)) begin errors++; $display("FAIL rmid_last[%0d] got=%b exp=%b", i, got_l[gb+i], i == 3); end
        end
    endtask

    task automatic test_empty_gap();
        int wb, gb;
        do_reset(); wb = wr_log.size(); gb = got_d.size();
        preload(2, 1'b0);
        bus.m_ready = 1'b1; enable = 1'b1;
        repeat (6) cyc();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got=%b exp=0", bus.m_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got=%b exp=1", busy); end
        repeat (5) cyc();
        preload(2, 1'b0);
        repeat (8) cyc();
        enable = 1'b0; wait_idle();
        checks++; if (got_d.size() - gb !== 4) begin errors++; $display("FAIL gap_count got=%0d exp=4", got_d.size() - gb); end
        for (int i = 0; i < 4 && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL gap_data[%0d] got=%h exp=%h", i, got_d[gb+i], wr_log[wb+i]); end
            checks++; if (got_l[gb+i] !== (i == 3)) begin errors++; $display("FAIL gap_last[%0d] got=%b exp=%b", i, got_l[gb+i], i == 3); end
        end
    endtask

    task automatic test_random();
        int wb, gb, n, sv0, ov0;
        do_reset(); wb = wr_log.size(); gb = got_d.size(); sv0 = stall_viol; ov0 = ovf_viol;
        enable = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bus.fifo_wr_en = ($urandom % 3) != 0;
            wdata          = DW'($urandom);
            bus.m_ready    = ($urandom % 4) != 0;
            cyc();
        end
        bus.fifo_wr_en = 1'b0; bus.m_ready = 1'b1;
        repeat (40) cyc();
        enable = 1'b0; wait_idle();
        n = wr_log.size() - wb;
        checks++; if (got_d.size() - gb !== n) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_d.size() - gb, n); end
        for (int i = 0; i < n && gb + i < got_d.size(); i++) begin
            checks++; if (got_d[gb+i] !== wr_log[wb+i]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_d[gb+i], wr_log[wb+i]); end
            checks++; if (got_l[gb+i] !== (i % BL == BL - 1)) begin errors++; $display("FAIL rand_last[%0d] got=%b exp=%b", i, got_l[gb+i], i % BL == BL - 1); end
        end
        checks++; if (stall_viol - sv0 !== 0) begin errors++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_viol - sv0); end
        checks++; if (ovf_viol - ov0 !== 0) begin errors++; $display("FAIL rand_overissue got=%0d exp=0", ovf_viol - ov0); end
    endtask

    initial begin
        bus.fifo_wr_en = 1'b0;
        bus.m_ready    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_write_collision();
        test_drain();
        test_reset_mid();
        test_empty_gap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
